fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, PC and address width in bits (>=8).
REQ-002 Parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-003 Parameter RESET_PC, default 0, fetch address after reset (word aligned).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 imem_addr  output  XLEN  current fetch PC to instruction memory.
REQ-008 imem_rdata  input  32  instruction at imem_addr, combinational same cycle.
REQ-009 redirect_valid  input  1  branch/jump taken; flush queue and refetch.
REQ-010 redirect_pc  input  XLEN  new fetch target.
REQ-011 deq_ready  input  1  decode accepts the head entry this cycle.
REQ-012 deq_valid  output  1  head entry present.
REQ-013 deq_instr  output  32  head instruction.
REQ-014 deq_pc_plus4  output  XLEN  head instruction's PC+4.
REQ-015 count  output  clog2(DEPTH)+1  occupied entries, 0..DEPTH.

Function
REQ-016 Internal state SHALL be the fetch PC, DEPTH-entry storage of {instr, pc_plus4}, read/write pointers, and count. Nothing else is registered.
REQ-017 imem_addr SHALL equal the fetch PC at all times.
REQ-018 Enqueue condition: !redirect_valid && (count<DEPTH || deq fires). On enqueue, write {imem_rdata, PC+4} at the write pointer and set PC <= PC+4.
REQ-019 Dequeue fires when deq_valid && deq_ready && !redirect_valid. It advances the read pointer.
REQ-020 deq_valid SHALL be (count!=0). deq_instr and deq_pc_plus4 SHALL be read combinationally from the head entry. Their value is don't-care while deq_valid=0.
REQ-021 count next state:
- +1 on enqueue only.
- -1 on dequeue only.
- Unchanged on both or neither.
REQ-022 Pointers SHALL wrap modulo DEPTH. PC+4 SHALL wrap modulo 2^XLEN.
REQ-023 Full (count==DEPTH) without dequeue: no enqueue, and the PC holds.
REQ-024 Full with a simultaneous dequeue: enqueue proceeds and count stays DEPTH.
REQ-025 Empty with deq_ready=1: no dequeue. An enqueue in the same cycle is visible at the head the next cycle.
REQ-026 On redirect_valid:
- Flush: count, read pointer and write pointer are set to 0.
- Set PC <= {redirect_pc[XLEN-1:2], 2'b00}.
- No enqueue or dequeue that cycle.
- Redirect has priority over all other activity.
REQ-027 Latency: the instruction at a new PC (after reset or redirect) SHALL appear with deq_valid=1 exactly one cycle after that PC is presented on imem_addr, provided the queue is not full.
REQ-028 Back-to-back redirects SHALL each take effect. Only the last one determines the PC.

Reset
REQ-029 While rst=1 at a rising edge:
- PC <= RESET_PC.
- count, read pointer and write pointer <= 0.
- Storage contents are don't-care.
REQ-030 Reset SHALL override redirect, enqueue and dequeue in the same cycle.
REQ-031 Reset outputs: deq_valid=0, count=0, imem_addr=RESET_PC.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries.

Verification
REQ-033 Reset then stream (DEPTH=4, RESET_PC=0, memory word n = 0x1000_0000+n, deq_ready=1): cycle 1 after reset deq_valid=1, deq_instr=0x10000000, deq_pc_plus4=4. One instruction per cycle follows and count stays 1.
REQ-034 Fill (deq_ready=0): count goes 1,2,3,4 then holds. imem_addr holds at 0x10. Releasing deq_ready yields instrs 0..3 in order, then 4.
REQ-035 Redirect while full (redirect_pc=0x43): next cycle count=0, deq_valid=0, imem_addr=0x40. One cycle later deq_pc_plus4=0x44.
REQ-036 Redirect and deq_ready in the same cycle with count=2: no dequeue is observed and the old entries never appear.
REQ-037 Wrap: XLEN=8 with PC=0xFC: deq_pc_plus4=0x00 and the next imem_addr=0x00. Pointers wrap after 5+ enqueues with no data loss.
REQ-038 rst asserted with count=3 and redirect_valid=1: next cycle count=0 and imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC generator feeding a DEPTH-entry queue of {instr, pc_plus4}.
module fetch_queue #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [XLEN-1:0]         imem_addr,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    input  logic                    deq_ready,
    output logic                    deq_valid,
    output logic [31:0]             deq_instr,
    output logic [XLEN-1:0]         deq_pc_plus4,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [XLEN-1:0] r_pc;
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [AW:0]     r_count;
    logic [31:0]     r_instr [DEPTH];
    logic [XLEN-1:0] r_pc4 [DEPTH];
    logic            w_deq;
    logic            w_enq;
    logic [XLEN-1:0] w_pc_next;
    // A full queue still accepts a fetch when its head leaves in the same cycle.
    always_comb begin
        w_deq = (r_count != '0) && deq_ready && !redirect_valid;
        w_enq = !redirect_valid && ((r_count != FULL) || w_deq);
        w_pc_next = r_pc + XLEN'(4);
    end
    assign imem_addr = r_pc;
    assign deq_valid = (r_count != '0);
    assign deq_instr = r_instr[r_rd];
    assign deq_pc_plus4 = r_pc4[r_rd];
    assign count = r_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_rd <= '0;
            r_wr <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            r_rd <= '0;
            r_wr <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_pc <= w_pc_next;
                r_wr <= r_wr + 1'b1;
            end
            if (w_deq)
                r_rd <= r_rd + 1'b1;
            r_count <= (w_enq && !w_deq) ? r_count + 1'b1 :
                       (w_deq && !w_enq) ? r_count - 1'b1 : r_count;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && w_enq) begin
            r_instr[r_wr] <= imem_rdata;
            r_pc4[r_wr] <= w_pc_next;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based reference model with a scoreboard monitor.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc_plus4;
    logic [2:0]  count;

    int total = 0;
    int bad = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    int          sz0;
    logic        p_rst, p_red, p_rdy;
    logic [31:0] p_rpc;
    bit          mon_en = 0;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_instr(deq_instr),
        .deq_pc_plus4(deq_pc_plus4), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction
    assign imem_rdata = mem(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the model for the edge just taken, then drive the next cycle's inputs.
    task automatic step(input logic r, input logic red, input logic rdy, input logic [31:0] rpc);
        bit deq;
        @(posedge clk);
        #1;
        if (p_rst) begin
            exp_q.delete();
            m_pc = 32'h0;
            mon_en = 1;
        end else if (p_red) begin
            exp_q.delete();
            m_pc = {p_rpc[31:2], 2'b00};
        end else begin
            deq = p_rdy && (sz0 > 0);
            if (sz0 < DEPTH || deq) begin
                exp_q.push_back({mem(m_pc), m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
        end
        rst = r; redirect_valid = red; deq_ready = rdy; redirect_pc = rpc;
        p_rst = r; p_red = red; p_rdy = rdy; p_rpc = rpc;
        sz0 = exp_q.size();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("count", count, exp_q.size());
            chk("deq_valid", deq_valid, exp_q.size() != 0);
            if (deq_valid && deq_ready && !redirect_valid && !rst) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_deq: got instr %0h expected no entry at %0t", deq_instr, $time);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("deq_instr", deq_instr, e[63:32]);
                    chk("deq_pc_plus4", deq_pc_plus4, e[31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1; redirect_valid = 0; deq_ready = 0; redirect_pc = 0;
        p_rst = 1; p_red = 0; p_rdy = 0; p_rpc = 0; sz0 = 0; m_pc = 0;
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        repeat (10) step(0, 0, 1, 0);
        repeat (8) step(0, 0, 0, 0);
        repeat (8) step(0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 0);
        step(0, 1, 0, 32'h43);
        repeat (2) step(0, 0, 0, 0);
        repeat (4) step(0, 0, 1, 0);
        step(0, 1, 0, 32'h200);
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 1, 32'h300);
        repeat (4) step(0, 0, 1, 0);
        step(0, 1, 0, 32'hFFFF_FFF8);
        repeat (6) step(0, 0, 0, 0);
        repeat (8) step(0, 0, 1, 0);
        step(0, 1, 0, 32'h800);
        repeat (3) step(0, 0, 0, 0);
        step(1, 1, 1, 32'h80);
        repeat (4) step(0, 0, 1, 0);
        step(0, 1, 1, 32'h400);
        step(0, 1, 1, 32'h503);
        repeat (4) step(0, 0, 1, 0);
        for (int i = 0; i < 800; i++)
            step(($urandom % 60) == 0, ($urandom % 8) == 0, ($urandom % 3) != 0, $urandom);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
